instr_fetch: RTL

- Instruction fetch/issue unit: the producing end of the decoder's Opcode interface.
- Holds the PC and fetches 9-bit instructions from instruction memory over a req/ack handshake.
- Presents Opcode and Operand fields to decode/execute over a valid/ready handshake.
- Takes branch redirects back from execute; signals Done when the program's last instruction retires.

---
 rtl/instr_fetch.sv | 138 +++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch/issue unit. It holds the PC, reads one instruction at a
// time from instruction memory over a req/ack handshake, and presents the
// decoded Opcode/Operand fields to decode/execute over a valid/ready
// handshake. Execute can redirect the PC in the cycle it accepts an
// instruction. o_done rises when the instruction at i_last_addr retires
// without a redirect.
//
// Ports
//   i_clk            clock, all state changes on the rising edge
//   i_reset          synchronous active-high reset
//   i_start          begin execution at PC 0 (only honoured in IDLE)
//   i_last_addr      address of the final program instruction
//   o_imem_req       instruction memory read request
//   o_imem_addr      read address (the PC)
//   i_imem_ack       read data valid on i_imem_data
//   i_imem_data      instruction word
//   o_inst_valid     instruction presented to decode
//   i_inst_ready     decode/execute accepts the instruction
//   o_opcode         IR[INST_W-1:INST_W-3]
//   o_operand        IR[INST_W-4:0]
//   o_inst_pc        PC of the presented instruction
//   i_branch_taken   redirect request, sampled only on acceptance
//   i_branch_target  redirect address
//   o_done           program complete, held until the next start
//   o_inst_count     retired-instruction count, saturating
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int PC_W   = 10,
    parameter int INST_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [PC_W-1:0]   i_last_addr,
    output logic              o_imem_req,
    output logic [PC_W-1:0]   o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [INST_W-1:0] i_imem_data,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [2:0]        o_opcode,
    output logic [INST_W-4:0] o_operand,
    output logic [PC_W-1:0]   o_inst_pc,
    input  logic              i_branch_taken,
    input  logic [PC_W-1:0]   i_branch_target,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_inst_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    logic [1:0]        r_state;
    logic [PC_W-1:0]   r_pc;
    logic [INST_W-1:0] r_ir;
    logic [CNT_W-1:0]  r_count;
    logic              r_done;

    logic w_accept;
    logic w_count_max;
    logic w_is_last;

    // Handshake outputs come straight from the state register, so neither
    // i_inst_ready nor i_imem_ack has a combinational path to an output.
    assign o_imem_req   = (r_state == ST_FETCH);
    assign o_inst_valid = (r_state == ST_ISSUE);
    assign o_imem_addr  = r_pc;
    assign o_inst_pc    = r_pc;
    assign o_opcode     = r_ir[INST_W-1:INST_W-3];
    assign o_operand    = r_ir[INST_W-4:0];
    assign o_done       = r_done;
    assign o_inst_count = r_count;

    assign w_accept    = (r_state == ST_ISSUE) && i_inst_ready;
    assign w_count_max = &r_count;
    assign w_is_last   = (r_pc == i_last_addr);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_pc    <= '0;
                        r_count <= '0;
                        r_done  <= 1'b0;
                        r_state <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    // Memory data is only captured while a request is open;
                    // stray acks in other states fall through untouched.
                    if (i_imem_ack) begin
                        r_ir    <= i_imem_data;
                        r_state <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (w_accept) begin
                        if (!w_count_max) begin
                            r_count <= r_count + 1'b1;
                        end
                        // A redirect out-ranks the end-of-program check, so
                        // a branch taken from the last address keeps running.
                        if (i_branch_taken) begin
                            r_pc    <= i_branch_target;
                            r_state <= ST_FETCH;
                        end else if (w_is_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            // Natural PC_W-bit wrap from all-ones to zero.
                            r_pc    <= r_pc + 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
